// File: rtl/vga_sdram_line_scheduler_if.sv
// SDRAM burst port between the line scheduler and the SDRAM controller.
//   oSdrReq  : burst request, held until iSdrAck
//   oSdrWr   : 1 = write (camera line), 0 = read (VGA line)
//   oSdrAddr : {frame bit, row*320}
//   iSdrAck  : one-cycle pulse, burst accepted
//   iSdrDone : one-cycle pulse, burst finished
// The master modport is the scheduler side; the slave modport is the controller.
interface vga_sdram_line_scheduler_if;
    logic        oSdrReq;
    logic        oSdrWr;
    logic [17:0] oSdrAddr;
    logic        iSdrAck;
    logic        iSdrDone;

    modport master (
        output oSdrReq,
        output oSdrWr,
        output oSdrAddr,
        input  iSdrAck,
        input  iSdrDone
    );

    modport slave (
        input  oSdrReq,
        input  oSdrWr,
        input  oSdrAddr,
        output iSdrAck,
        output iSdrDone
    );
endinterface

// File: rtl/vga_sdram_line_scheduler.sv
// Schedules every SDRAM burst of the camera-to-VGA frame path.
// VGA line reloads (iTag strobes) and camera line writes (iCamReq) share one
// SDRAM burst port; a pending read always wins over a camera write. The VGA
// line buffer half is flipped after each read burst, and the two frame
// buffers are swapped only once both camera and display finished a frame.
// Ports:
//   clk, rst      : pixel clock, asynchronous active-high reset
//   iTag          : [10] reload strobe, [9:0] row to load
//   iCamReq/Row   : camera line ready + its row
//   iCamFrameEnd  : camera finished a frame (pulse)
//   iVgaFrameEnd  : display vertical wrap (pulse)
//   oCamAck       : camera line written (or dropped as a bad row), pulse
//   sdr           : SDRAM burst port (master side)
//   oBufSel       : line-buffer half being filled; VGA reads the other half
//   oFrameSel     : frame buffer the camera writes; VGA reads the other one
//   oErrCnt       : saturating count of read overruns and bad camera rows
module vga_sdram_line_scheduler (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [10:0]                       iTag,
    input  logic                              iCamReq,
    input  logic [9:0]                        iCamRow,
    input  logic                              iCamFrameEnd,
    input  logic                              iVgaFrameEnd,
    output logic                              oCamAck,
    vga_sdram_line_scheduler_if.master        sdr,
    output logic                              oBufSel,
    output logic                              oFrameSel,
    output logic [7:0]                        oErrCnt
);

    localparam logic [9:0] YSIZE = 10'd240;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BUSY, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        rd_pend_q, rd_pend_d;
    logic [9:0]  rd_row_q, rd_row_d;
    logic        wr_q, wr_d;
    logic [17:0] addr_q, addr_d;
    logic        buf_sel_q, buf_sel_d;
    logic        frame_sel_q, frame_sel_d;
    logic        cam_done_q, cam_done_d;
    logic        vga_done_q, vga_done_d;
    logic [7:0]  err_q, err_d;

    logic        tag_valid;
    logic        rd_grant;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    // Line offset row*320 as (row<<8)+(row<<6); 17 bits cover every row < 240.
    function automatic logic [16:0] row_offset(input logic [9:0] row);
        logic [16:0] r17;
        r17 = {7'd0, row};
        return (r17 << 8) + (r17 << 6);
    endfunction

    assign tag_valid = iTag[10] && (iTag[9:0] < YSIZE);

    always_comb begin
        state_d     = state_q;
        rd_pend_d   = rd_pend_q;
        rd_row_d    = rd_row_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        buf_sel_d   = buf_sel_q;
        frame_sel_d = frame_sel_q;
        cam_done_d  = cam_done_q;
        vga_done_d  = vga_done_q;
        rd_grant    = 1'b0;
        err_inc     = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (rd_pend_q) begin
                    state_d  = S_REQ;
                    wr_d     = 1'b0;
                    addr_d   = {~frame_sel_q, row_offset(rd_row_q)};
                    rd_grant = 1'b1;
                end else if (iCamReq) begin
                    // wr_q also marks a dropped bad row so DONE acks the camera.
                    wr_d = 1'b1;
                    if (iCamRow < YSIZE) begin
                        state_d = S_REQ;
                        addr_d  = {frame_sel_q, row_offset(iCamRow)};
                    end else begin
                        state_d = S_DONE;
                        err_inc = err_inc + 2'd1;
                    end
                end
            end
            S_REQ: begin
                if (sdr.iSdrAck) state_d = S_BUSY;
            end
            S_BUSY: begin
                if (sdr.iSdrDone) begin
                    state_d = S_DONE;
                    // Flip on entry to DONE so the new half is visible there.
                    if (!wr_q) buf_sel_d = ~buf_sel_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new strobe beats a grant on the same edge; only a strobe that
        // replaces a still-unserviced row counts as an overrun.
        if (tag_valid) begin
            if (rd_pend_q && !rd_grant) err_inc = err_inc + 2'd1;
            rd_pend_d = 1'b1;
            rd_row_d  = iTag[9:0];
        end else if (rd_grant) begin
            rd_pend_d = 1'b0;
        end

        // Swap only between bursts so no burst straddles two frames.
        if (cam_done_q && vga_done_q && (state_q == S_IDLE)) begin
            frame_sel_d = ~frame_sel_q;
            cam_done_d  = 1'b0;
            vga_done_d  = 1'b0;
        end
        if (iCamFrameEnd) cam_done_d = 1'b1;
        if (iVgaFrameEnd) vga_done_d = 1'b1;

        err_sum = {1'b0, err_q} + {7'd0, err_inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_pend_q   <= 1'b0;
            rd_row_q    <= 10'd0;
            wr_q        <= 1'b0;
            addr_q      <= 18'd0;
            buf_sel_q   <= 1'b0;
            frame_sel_q <= 1'b0;
            cam_done_q  <= 1'b0;
            vga_done_q  <= 1'b0;
            err_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            rd_row_q    <= rd_row_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            buf_sel_q   <= buf_sel_d;
            frame_sel_q <= frame_sel_d;
            cam_done_q  <= cam_done_d;
            vga_done_q  <= vga_done_d;
            err_q       <= err_d;
        end
    end

    assign sdr.oSdrReq  = (state_q == S_REQ);
    assign sdr.oSdrWr   = wr_q;
    assign sdr.oSdrAddr = addr_q;
    assign oCamAck      = (state_q == S_DONE) && wr_q;
    assign oBufSel      = buf_sel_q;
    assign oFrameSel    = frame_sel_q;
    assign oErrCnt      = err_q;

endmodule

// File: tb/tb_vga_sdram_line_scheduler.sv
module tb_vga_sdram_line_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] iTag;
    logic        iCamReq;
    logic [9:0]  iCamRow;
    logic        iCamFrameEnd;
    logic        iVgaFrameEnd;
    logic        oCamAck;
    logic        oBufSel;
    logic        oFrameSel;
    logic [7:0]  oErrCnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit m_buf   = 1'b0;
    bit m_frame = 1'b0;
    int m_err   = 0;

    vga_sdram_line_scheduler_if sdr_if ();

    vga_sdram_line_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .iTag         (iTag),
        .iCamReq      (iCamReq),
        .iCamRow      (iCamRow),
        .iCamFrameEnd (iCamFrameEnd),
        .iVgaFrameEnd (iVgaFrameEnd),
        .oCamAck      (oCamAck),
        .sdr          (sdr_if),
        .oBufSel      (oBufSel),
        .oFrameSel    (oFrameSel),
        .oErrCnt      (oErrCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected burst address from the frame bit and the row, plain arithmetic.
    function automatic logic [17:0] mk_addr(input bit fr, input int row);
        logic [16:0] off;
        off = 17'(row * 320);
        return {fr, off};
    endfunction

    task automatic wait_req(input int maxc);
        int n;
        n = 0;
        while (sdr_if.oSdrReq !== 1'b1 && n < maxc) begin
            step();
            n++;
        end
        check("req_seen", {31'd0, sdr_if.oSdrReq}, 32'd1);
    endtask

    // Acts as the SDRAM controller for one burst; returns in the DONE cycle.
    task automatic serve(input int ack_dly, input int done_dly);
        logic [17:0] a0;
        a0 = sdr_if.oSdrAddr;
        for (int i = 0; i < ack_dly; i++) begin
            step();
            check("req_hold", {31'd0, sdr_if.oSdrReq}, 32'd1);
            check("addr_hold", {14'd0, sdr_if.oSdrAddr}, {14'd0, a0});
        end
        sdr_if.iSdrAck = 1'b1;
        step();
        sdr_if.iSdrAck = 1'b0;
        check("req_drop", {31'd0, sdr_if.oSdrReq}, 32'd0);
        for (int i = 0; i < done_dly; i++) step();
        sdr_if.iSdrDone = 1'b1;
        step();
        sdr_if.iSdrDone = 1'b0;
    endtask

    initial begin
        int kind, ra, rb;
        bit same;

        rst = 1'b1;
        iTag = 11'd0;
        iCamReq = 1'b0;
        iCamRow = 10'd0;
        iCamFrameEnd = 1'b0;
        iVgaFrameEnd = 1'b0;
        sdr_if.iSdrAck = 1'b0;
        sdr_if.iSdrDone = 1'b0;
        repeat (3) step();
        check("rst_req", {31'd0, sdr_if.oSdrReq}, 32'd0);
        check("rst_wr", {31'd0, sdr_if.oSdrWr}, 32'd0);
        check("rst_addr", {14'd0, sdr_if.oSdrAddr}, 32'd0);
        check("rst_ack", {31'd0, oCamAck}, 32'd0);
        check("rst_buf", {31'd0, oBufSel}, 32'd0);
        check("rst_frame", {31'd0, oFrameSel}, 32'd0);
        check("rst_err", {24'd0, oErrCnt}, 32'd0);
        rst = 1'b0;
        step();

        // 1: read row 5, exact two-cycle latency
        iTag = {1'b1, 10'd5};
        step();
        iTag = 11'd0;
        check("rd_lat1", {31'd0, sdr_if.oSdrReq}, 32'd0);
        step();
        check("rd_lat2", {31'd0, sdr_if.oSdrReq}, 32'd1);
        check("rd_wr", {31'd0, sdr_if.oSdrWr}, 32'd0);
        check("rd_addr", {14'd0, sdr_if.oSdrAddr}, 32'h20640);
        serve(2, 6);
        m_buf = ~m_buf;
        check("rd_buf", {31'd0, oBufSel}, {31'd0, m_buf});
        check("rd_noack", {31'd0, oCamAck}, 32'd0);
        step();
        $display("read row 5 done buf=%0d", oBufSel);

        // 2: camera write row 239
        iCamReq = 1'b1;
        iCamRow = 10'd239;
        step();
        check("wr_req", {31'd0, sdr_if.oSdrReq}, 32'd1);
        check("wr_wr", {31'd0, sdr_if.oSdrWr}, 32'd1);
        check("wr_addr", {14'd0, sdr_if.oSdrAddr}, 32'd76480);
        serve(1, 3);
        check("wr_ack", {31'd0, oCamAck}, 32'd1);
        iCamReq = 1'b0;
        step();
        check("wr_ack_once", {31'd0, oCamAck}, 32'd0);
        $display("camera row 239 written");

        // 3: overrun during a camera write
        iCamReq = 1'b1;
        iCamRow = 10'd10;
        wait_req(4);
        sdr_if.iSdrAck = 1'b1;
        step();
        sdr_if.iSdrAck = 1'b0;
        iTag = {1'b1, 10'd7};
        step();
        iTag = {1'b1, 10'd8};
        step();
        iTag = 11'd0;
        m_err = 1;
        check("ovr_err", {24'd0, oErrCnt}, m_err);
        sdr_if.iSdrDone = 1'b1;
        step();
        sdr_if.iSdrDone = 1'b0;
        check("ovr_wrack", {31'd0, oCamAck}, 32'd1);
        iCamReq = 1'b0;
        wait_req(4);
        check("ovr_rd_wr", {31'd0, sdr_if.oSdrWr}, 32'd0);
        check("ovr_rd_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(~m_frame, 8)});
        serve(0, 1);
        m_buf = ~m_buf;
        check("ovr_buf", {31'd0, oBufSel}, {31'd0, m_buf});
        step();
        $display("overrun then read row 8 err=%0d", oErrCnt);

        // 4: tag 240 ignored; camera row 300 dropped with error
        iTag = {1'b1, 10'd240};
        step();
        iTag = 11'd0;
        repeat (3) step();
        check("t240_noreq", {31'd0, sdr_if.oSdrReq}, 32'd0);
        check("t240_err", {24'd0, oErrCnt}, m_err);
        iCamReq = 1'b1;
        iCamRow = 10'd300;
        step();
        m_err++;
        check("bad_noreq", {31'd0, sdr_if.oSdrReq}, 32'd0);
        check("bad_ack", {31'd0, oCamAck}, 32'd1);
        check("bad_err", {24'd0, oErrCnt}, m_err);
        iCamReq = 1'b0;
        step();
        check("bad_ack_end", {31'd0, oCamAck}, 32'd0);
        $display("bad rows handled err=%0d", oErrCnt);

        // 5: frame swap deferred until IDLE
        iCamReq = 1'b1;
        iCamRow = 10'd20;
        wait_req(4);
        sdr_if.iSdrAck = 1'b1;
        step();
        sdr_if.iSdrAck = 1'b0;
        iCamFrameEnd = 1'b1;
        step();
        iCamFrameEnd = 1'b0;
        iVgaFrameEnd = 1'b1;
        step();
        iVgaFrameEnd = 1'b0;
        iCamFrameEnd = 1'b1;
        step();
        iCamFrameEnd = 1'b0;
        check("swap_busy", {31'd0, oFrameSel}, {31'd0, m_frame});
        sdr_if.iSdrDone = 1'b1;
        step();
        sdr_if.iSdrDone = 1'b0;
        iCamReq = 1'b0;
        check("swap_done", {31'd0, oFrameSel}, {31'd0, m_frame});
        step();
        check("swap_idle0", {31'd0, oFrameSel}, {31'd0, m_frame});
        step();
        m_frame = ~m_frame;
        check("swap_idle1", {31'd0, oFrameSel}, {31'd0, m_frame});
        repeat (3) step();
        check("swap_once", {31'd0, oFrameSel}, {31'd0, m_frame});
        $display("frame swapped frame=%0d", oFrameSel);

        // 6: async reset while in REQ
        iCamReq = 1'b1;
        iCamRow = 10'd50;
        step();
        check("rq_req", {31'd0, sdr_if.oSdrReq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_req", {31'd0, sdr_if.oSdrReq}, 32'd0);
        check("ar_addr", {14'd0, sdr_if.oSdrAddr}, 32'd0);
        check("ar_wr", {31'd0, sdr_if.oSdrWr}, 32'd0);
        check("ar_buf", {31'd0, oBufSel}, 32'd0);
        check("ar_frame", {31'd0, oFrameSel}, 32'd0);
        check("ar_err", {24'd0, oErrCnt}, 32'd0);
        m_buf = 1'b0;
        m_frame = 1'b0;
        m_err = 0;
        step();
        rst = 1'b0;
        step();
        check("rr_req", {31'd0, sdr_if.oSdrReq}, 32'd1);
        check("rr_wr", {31'd0, sdr_if.oSdrWr}, 32'd1);
        check("rr_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(m_frame, 50)});
        serve(1, 1);
        check("rr_ack", {31'd0, oCamAck}, 32'd1);
        iCamReq = 1'b0;
        step();
        $display("reset mid-burst recovered");

        // 7: randomized operations against the model
        for (int op = 0; op < 40; op++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    ra = $urandom_range(0, 255);
                    iTag = {1'b1, 10'(ra)};
                    step();
                    iTag = 11'd0;
                    if (ra >= 240) begin
                        repeat (3) step();
                        check("r_rd_ign", {31'd0, sdr_if.oSdrReq}, 32'd0);
                    end else begin
                        wait_req(4);
                        check("r_rd_wr", {31'd0, sdr_if.oSdrWr}, 32'd0);
                        check("r_rd_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(~m_frame, ra)});
                        serve($urandom_range(0, 3), $urandom_range(0, 5));
                        m_buf = ~m_buf;
                        check("r_rd_buf", {31'd0, oBufSel}, {31'd0, m_buf});
                        step();
                    end
                    $display("op %0d read row %0d", op, ra);
                end
                1: begin
                    ra = $urandom_range(0, 269);
                    iCamReq = 1'b1;
                    iCamRow = 10'(ra);
                    if (ra >= 240) begin
                        step();
                        m_err = (m_err < 255) ? m_err + 1 : 255;
                        check("r_bad_noreq", {31'd0, sdr_if.oSdrReq}, 32'd0);
                    end else begin
                        wait_req(4);
                        check("r_wr_wr", {31'd0, sdr_if.oSdrWr}, 32'd1);
                        check("r_wr_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(m_frame, ra)});
                        serve($urandom_range(0, 3), $urandom_range(0, 5));
                    end
                    check("r_cam_ack", {31'd0, oCamAck}, 32'd1);
                    iCamReq = 1'b0;
                    step();
                    check("r_cam_ack_end", {31'd0, oCamAck}, 32'd0);
                    $display("op %0d camera row %0d", op, ra);
                end
                2: begin
                    same = 1'($urandom_range(0, 1));
                    iCamFrameEnd = 1'b1;
                    iVgaFrameEnd = same;
                    step();
                    iCamFrameEnd = 1'b0;
                    iVgaFrameEnd = ~same;
                    step();
                    iVgaFrameEnd = 1'b0;
                    repeat (2) step();
                    m_frame = ~m_frame;
                    check("r_frame", {31'd0, oFrameSel}, {31'd0, m_frame});
                    $display("op %0d frame swap frame=%0d", op, oFrameSel);
                end
                default: begin
                    // second strobe lands on the grant edge of the first
                    ra = $urandom_range(0, 239);
                    rb = $urandom_range(0, 239);
                    iTag = {1'b1, 10'(ra)};
                    step();
                    iTag = {1'b1, 10'(rb)};
                    step();
                    iTag = 11'd0;
                    check("r_two_a_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(~m_frame, ra)});
                    serve($urandom_range(0, 2), $urandom_range(0, 3));
                    m_buf = ~m_buf;
                    wait_req(4);
                    check("r_two_b_addr", {14'd0, sdr_if.oSdrAddr}, {14'd0, mk_addr(~m_frame, rb)});
                    serve($urandom_range(0, 2), $urandom_range(0, 3));
                    m_buf = ~m_buf;
                    check("r_two_buf", {31'd0, oBufSel}, {31'd0, m_buf});
                    step();
                    $display("op %0d back-to-back reads %0d %0d", op, ra, rb);
                end
            endcase
            check("r_err", {24'd0, oErrCnt}, m_err);
        end

        // 8: error counter saturation
        for (int i = 0; i < 260; i++) begin
            iCamReq = 1'b1;
            iCamRow = 10'(240 + $urandom_range(0, 700));
            step();
            iCamReq = 1'b0;
            step();
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end
        check("sat_err", {24'd0, oErrCnt}, m_err);
        $display("saturation err=%0d", oErrCnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
